// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - March C- element encoding, operation type and data patterns
package mbist_pkg;

    typedef enum logic [2:0] {
        E0    = 3'd0,
        E1    = 3'd1,
        E2    = 3'd2,
        E3    = 3'd3,
        E4    = 3'd4,
        E5    = 3'd5,
        DRAIN = 3'd6
    } elem_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam logic [31:0] PAT0 = 32'h0000_0000;
    localparam logic [31:0] PAT1 = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        down;
        logic [31:0] rd_pat;
        logic [31:0] wr_pat;
    } elem_info_t;

    function automatic elem_info_t elem_info(input elem_e e);
        elem_info_t info;
        info = '{down: 1'b0, rd_pat: PAT0, wr_pat: PAT0};
        case (e)
            E1: info.wr_pat = PAT1;
            E2: info.rd_pat = PAT1;
            E3: begin
                info.down   = 1'b1;
                info.wr_pat = PAT1;
            end
            E4: begin
                info.down   = 1'b1;
                info.rd_pat = PAT1;
            end
            default: ;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/sram_mbist_mux_if.sv
// rtl/sram_mbist_mux_if.sv - single-port synchronous SRAM access port
interface sram_mbist_mux_if #(parameter int AW = 12);
    logic            cs;
    logic [3:0]      wen;
    logic [31:0]     wdata;
    logic [AW-3:0]   addr;
    logic [31:0]     rdata;

    modport master (output cs, wen, wdata, addr, input rdata);
    modport slave  (input cs, wen, wdata, addr, output rdata);
endinterface

// File: rtl/sram_march_seq.sv
// rtl/sram_march_seq.sv - March C- element sequencer with up/down address counter
module sram_march_seq
    import mbist_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          active,
    output logic          cs,
    output op_e           op,
    output logic [AW-3:0] addr,
    output logic [31:0]   wdata,
    output logic [31:0]   exp_data,
    output logic [2:0]    elem_tag,
    output logic          drain
);
    localparam int WA = AW - 2;
    localparam logic [WA-1:0] ADDR_LAST = '1;

    logic          active_q, active_d;
    elem_e         elem_q, elem_d;
    op_e           phase_q, phase_d;
    logic [WA-1:0] addr_q, addr_d;

    elem_info_t    cur_info, nxt_info;
    logic [WA-1:0] end_addr;

    always_comb begin
        cur_info = elem_info(elem_q);
        nxt_info = elem_info(elem_e'(elem_q + 3'd1));
        end_addr = cur_info.down ? '0 : ADDR_LAST;
        active_d = active_q;
        elem_d   = elem_q;
        phase_d  = phase_q;
        addr_d   = addr_q;
        if (!active_q) begin
            if (start) begin
                active_d = 1'b1;
                elem_d   = E0;
                phase_d  = OP_WR;
                addr_d   = '0;
            end
        end else begin
            case (elem_q)
                E0: begin
                    if (addr_q == ADDR_LAST) begin
                        elem_d  = E1;
                        phase_d = OP_RD;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                E1, E2, E3, E4: begin
                    if (phase_q == OP_RD) begin
                        phase_d = OP_WR;
                    end else begin
                        // every element after E1 opens with a read
                        phase_d = OP_RD;
                        if (addr_q == end_addr) begin
                            elem_d = elem_e'(elem_q + 3'd1);
                            addr_d = nxt_info.down ? ADDR_LAST : '0;
                        end else if (cur_info.down) begin
                            addr_d = addr_q - 1'b1;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                E5: begin
                    if (addr_q == ADDR_LAST) begin
                        elem_d = DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                default: begin
                    active_d = 1'b0;
                    elem_d   = E0;
                    phase_d  = OP_WR;
                    addr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            elem_q   <= E0;
            phase_q  <= OP_WR;
            addr_q   <= '0;
        end else begin
            active_q <= active_d;
            elem_q   <= elem_d;
            phase_q  <= phase_d;
            addr_q   <= addr_d;
        end
    end

    assign active   = active_q;
    assign cs       = active_q && (elem_q != DRAIN);
    assign op       = phase_q;
    assign addr     = addr_q;
    assign wdata    = cur_info.wr_pat;
    assign exp_data = cur_info.rd_pat;
    assign elem_tag = elem_q;
    assign drain    = active_q && (elem_q == DRAIN);

endmodule

// File: rtl/sram_mbist_mux.sv
// rtl/sram_mbist_mux.sv - memory BIST engine and SRAM port mux between bridge and SRAM
module sram_mbist_mux
    import mbist_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic             HCLK,
    input  logic             HRESET,
    sram_mbist_mux_if.slave  f_port,
    sram_mbist_mux_if.master sram_port,
    input  logic             bist_start,
    output logic             bist_active,
    output logic             bist_done,
    output logic             bist_fail,
    output logic [AW-3:0]    bist_fail_addr,
    output logic [2:0]       bist_fail_elem
);
    localparam int WA = AW - 2;

    logic          seq_cs;
    op_e           seq_op;
    logic [WA-1:0] seq_addr;
    logic [31:0]   seq_wdata;
    logic [31:0]   seq_exp;
    logic [2:0]    seq_elem;
    logic          seq_drain;

    sram_march_seq #(.AW(AW)) u_seq (
        .clk      (HCLK),
        .rst      (HRESET),
        .start    (bist_start),
        .active   (bist_active),
        .cs       (seq_cs),
        .op       (seq_op),
        .addr     (seq_addr),
        .wdata    (seq_wdata),
        .exp_data (seq_exp),
        .elem_tag (seq_elem),
        .drain    (seq_drain)
    );

    // mux select is the registered active flag, so bist_start never reaches the SRAM pins
    always_comb begin
        sram_port.cs    = f_port.cs;
        sram_port.wen   = f_port.wen;
        sram_port.wdata = f_port.wdata;
        sram_port.addr  = f_port.addr;
        if (bist_active) begin
            sram_port.cs    = seq_cs;
            sram_port.wen   = (seq_op == OP_WR) ? 4'hF : 4'h0;
            sram_port.wdata = seq_wdata;
            sram_port.addr  = seq_addr;
        end
    end

    assign f_port.rdata = sram_port.rdata;

    logic          cmp_vld_q, cmp_vld_d;
    logic [31:0]   cmp_exp_q, cmp_exp_d;
    logic [WA-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]    cmp_elem_q, cmp_elem_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic [WA-1:0] faddr_q, faddr_d;
    logic [2:0]    felem_q, felem_d;
    logic          mismatch;

    always_comb begin
        cmp_vld_d  = bist_active && seq_cs && (seq_op == OP_RD);
        cmp_exp_d  = seq_exp;
        cmp_addr_d = seq_addr;
        cmp_elem_d = seq_elem;
        mismatch   = cmp_vld_q && (sram_port.rdata != cmp_exp_q);
        done_d     = done_q;
        fail_d     = fail_q;
        faddr_d    = faddr_q;
        felem_d    = felem_q;
        if (bist_start && !bist_active) begin
            done_d  = 1'b0;
            fail_d  = 1'b0;
            faddr_d = '0;
            felem_d = '0;
        end else begin
            if (mismatch) begin
                fail_d = 1'b1;
                if (!fail_q) begin
                    faddr_d = cmp_addr_q;
                    felem_d = cmp_elem_q;
                end
            end
            if (seq_drain) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cmp_vld_q  <= 1'b0;
            cmp_exp_q  <= '0;
            cmp_addr_q <= '0;
            cmp_elem_q <= '0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            faddr_q    <= '0;
            felem_q    <= '0;
        end else begin
            cmp_vld_q  <= cmp_vld_d;
            cmp_exp_q  <= cmp_exp_d;
            cmp_addr_q <= cmp_addr_d;
            cmp_elem_q <= cmp_elem_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            faddr_q    <= faddr_d;
            felem_q    <= felem_d;
        end
    end

    assign bist_done      = done_q;
    assign bist_fail      = fail_q;
    assign bist_fail_addr = faddr_q;
    assign bist_fail_elem = felem_q;

endmodule

// File: tb/tb_sram_mbist_mux.sv
// tb/tb_sram_mbist_mux.sv - scoreboard bench for sram_mbist_mux with a faulty SRAM model
module tb_sram_mbist_mux;
    localparam int AW = 4;
    localparam int WA = AW - 2;
    localparam int N  = 1 << WA;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          bist_start = 1'b0;
    logic          bist_active, bist_done, bist_fail;
    logic [WA-1:0] bist_fail_addr;
    logic [2:0]    bist_fail_elem;

    sram_mbist_mux_if #(.AW(AW)) f_if ();
    sram_mbist_mux_if #(.AW(AW)) s_if ();

    sram_mbist_mux #(.AW(AW)) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .f_port         (f_if),
        .sram_port      (s_if),
        .bist_start     (bist_start),
        .bist_active    (bist_active),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
        .bist_fail_addr (bist_fail_addr),
        .bist_fail_elem (bist_fail_elem)
    );

    always #5 HCLK = ~HCLK;

    logic [31:0] mem [N];
    logic [31:0] sa1 [N];
    logic [31:0] sa0 [N];

    always @(posedge HCLK) begin
        if (s_if.cs) begin
            if (s_if.wen != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (s_if.wen[b]) mem[s_if.addr][8*b +: 8] <= s_if.wdata[8*b +: 8];
            end else begin
                s_if.rdata <= (mem[s_if.addr] | sa1[s_if.addr]) & ~sa0[s_if.addr];
            end
        end
    end

    typedef struct {
        logic          cs;
        logic          wr;
        logic [WA-1:0] addr;
        logic [31:0]   wdata;
    } op_t;

    typedef struct {
        int            dur;
        logic          fail;
        logic [WA-1:0] faddr;
        logic [2:0]    felem;
    } res_t;

    op_t  op_q [$];
    res_t res_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // reference: walk the March C- element table over an ideal memory with the same stuck bits
    task automatic build_run();
        int          dn [6] = '{0, 0, 0, 1, 1, 0};
        int          rp [6] = '{-1, 0, 1, 0, 1, 0};
        int          wp [6] = '{0, 1, 0, 1, 0, -1};
        logic [31:0] m [N];
        logic        f = 1'b0;
        int          fa = 0, fe = 0, a;
        logic [31:0] v, p;
        op_t         o;
        res_t        r;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (dn[e] != 0) ? N - 1 - i : i;
                if (rp[e] >= 0) begin
                    o.cs = 1'b1; o.wr = 1'b0; o.addr = WA'(a); o.wdata = 32'h0;
                    op_q.push_back(o);
                    v = (m[a] | sa1[a]) & ~sa0[a];
                    p = (rp[e] != 0) ? 32'hFFFF_FFFF : 32'h0;
                    if (v !== p && !f) begin
                        f = 1'b1; fa = a; fe = e;
                    end
                end
                if (wp[e] >= 0) begin
                    p = (wp[e] != 0) ? 32'hFFFF_FFFF : 32'h0;
                    o.cs = 1'b1; o.wr = 1'b1; o.addr = WA'(a); o.wdata = p;
                    op_q.push_back(o);
                    m[a] = p;
                end
            end
        end
        o.cs = 1'b0; o.wr = 1'b0; o.addr = '0; o.wdata = 32'h0;
        op_q.push_back(o);
        r.dur = 10 * N + 1; r.fail = f; r.faddr = WA'(fa); r.felem = 3'(fe);
        res_q.push_back(r);
    endtask

    initial begin : monitor
        logic prev = 1'b0;
        int   cnt = 0;
        op_t  o;
        res_t r;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                prev = 1'b0;
                cnt  = 0;
                continue;
            end
            if (bist_active) begin
                cnt++;
                if (op_q.size() == 0) begin
                    chk("unexpected_bist_cycle", 64'(cnt), 64'(10 * N + 1));
                end else begin
                    o = op_q.pop_front();
                    chk("op_cs", 64'(s_if.cs), 64'(o.cs));
                    if (o.cs) begin
                        chk("op_wen", 64'(s_if.wen), o.wr ? 64'hF : 64'h0);
                        chk("op_addr", 64'(s_if.addr), 64'(o.addr));
                        if (o.wr) chk("op_wdata", 64'(s_if.wdata), 64'(o.wdata));
                    end
                end
            end else if (prev) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_run_end", 64'(res_q.size()), 64'd1);
                end else begin
                    r = res_q.pop_front();
                    chk("run_duration", 64'(cnt), 64'(r.dur));
                    chk("run_done", 64'(bist_done), 64'd1);
                    chk("run_fail", 64'(bist_fail), 64'(r.fail));
                    chk("run_fail_addr", 64'(bist_fail_addr), 64'(r.faddr));
                    chk("run_fail_elem", 64'(bist_fail_elem), 64'(r.felem));
                    chk("run_ops_left", 64'(op_q.size()), 64'd0);
                end
                cnt = 0;
            end
            prev = bist_active;
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa1[i] = 32'h0;
            sa0[i] = 32'h0;
        end
    endtask

    task automatic run_bist();
        @(posedge HCLK);
        #1 bist_start = 1'b1;
        build_run();
        @(posedge HCLK);
        #1 bist_start = 1'b0;
        chk("start_active", 64'(bist_active), 64'd1);
        chk("start_done_clr", 64'(bist_done), 64'd0);
        chk("start_fail_clr", 64'(bist_fail), 64'd0);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200; i++) begin
            @(posedge HCLK);
            #1;
            f_if.cs    = 1'($urandom_range(0, 1));
            f_if.wen   = 4'($urandom);
            f_if.wdata = $urandom;
            f_if.addr  = WA'($urandom);
            if (!bist_active) break;
        end
        f_if.cs = 1'b0;
        if (i >= 200) chk("run_timeout", 64'(bist_active), 64'd0);
    endtask

    task automatic pt_write_read(input logic [WA-1:0] a, input logic [31:0] d);
        f_if.cs = 1'b1; f_if.wen = 4'hF; f_if.wdata = d; f_if.addr = a;
        #1;
        chk("pt_wr_cs", 64'(s_if.cs), 64'd1);
        chk("pt_wr_wen", 64'(s_if.wen), 64'hF);
        chk("pt_wr_wdata", 64'(s_if.wdata), 64'(d));
        chk("pt_wr_addr", 64'(s_if.addr), 64'(a));
        @(posedge HCLK);
        #1 f_if.wen = 4'h0;
        #1;
        chk("pt_rd_wen", 64'(s_if.wen), 64'h0);
        chk("pt_rd_addr", 64'(s_if.addr), 64'(a));
        @(posedge HCLK);
        #1 f_if.cs = 1'b0;
        chk("pt_rdata", 64'(f_if.rdata), 64'(d));
    endtask

    initial begin : stimulus
        logic [31:0] d;
        int          w, b;
        f_if.cs = 1'b0; f_if.wen = 4'h0; f_if.wdata = 32'h0; f_if.addr = '0;
        clear_faults();
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_active", 64'(bist_active), 64'd0);
        chk("rst_done", 64'(bist_done), 64'd0);
        chk("rst_fail", 64'(bist_fail), 64'd0);
        chk("rst_fail_addr", 64'(bist_fail_addr), 64'd0);
        chk("rst_fail_elem", 64'(bist_fail_elem), 64'd0);
        HRESET = 1'b0;

        @(posedge HCLK);
        #1 pt_write_read(WA'(1), 32'hDEADBEEF);

        // functional read issued in the takeover cycle still returns its data
        @(posedge HCLK);
        #1;
        f_if.cs = 1'b1; f_if.wen = 4'h0; f_if.addr = WA'(1);
        bist_start = 1'b1;
        build_run();
        @(posedge HCLK);
        #1;
        bist_start = 1'b0;
        f_if.cs = 1'b0;
        chk("takeover_rdata", 64'(f_if.rdata), 64'hDEADBEEF);
        wait_idle();

        sa1[2] = 32'h0000_0008;
        run_bist();
        wait_idle();
        clear_faults();

        sa0[3] = 32'h0000_0001;
        run_bist();
        wait_idle();
        clear_faults();

        // second start mid-run is ignored; fresh start clears the previous failure
        run_bist();
        repeat (9) @(posedge HCLK);
        #1 bist_start = 1'b1;
        @(posedge HCLK);
        #1 bist_start = 1'b0;
        wait_idle();

        for (int k = 0; k < 4; k++) begin
            clear_faults();
            w = $urandom_range(0, N - 1);
            b = $urandom_range(0, 31);
            if ($urandom_range(0, 1) != 0) sa1[w] = 32'h1 << b;
            else sa0[w] = 32'h1 << b;
            if (k == 3) sa1[$urandom_range(0, N - 1)] |= 32'h1 << $urandom_range(0, 31);
            run_bist();
            wait_idle();
        end
        clear_faults();

        sa1[0] = 32'h8000_0000;
        run_bist();
        repeat (18) @(posedge HCLK);
        #3 HRESET = 1'b1;
        op_q.delete();
        res_q.delete();
        #1;
        chk("midrst_active", 64'(bist_active), 64'd0);
        chk("midrst_done", 64'(bist_done), 64'd0);
        chk("midrst_fail", 64'(bist_fail), 64'd0);
        chk("midrst_fail_addr", 64'(bist_fail_addr), 64'd0);
        chk("midrst_fail_elem", 64'(bist_fail_elem), 64'd0);
        clear_faults();
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        d = $urandom;
        pt_write_read(WA'(2), d);

        repeat (3) @(posedge HCLK);
        #1;
        chk("end_ops_empty", 64'(op_q.size()), 64'd0);
        chk("end_res_empty", 64'(res_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_mbist_mux.md
Name: sram_mbist_mux

Overview:
Memory-BIST engine and port multiplexer between the AHB SRAM bridge's SRAM-side port and the physical single-port synchronous SRAM. When idle, it passes the bridge's SRAM signals straight through. On request, it takes the SRAM port and runs a March C- test over every word, then reports pass/fail with the first failing word address and march element. It also provides bist_active, which the system uses to stall AHB (gate HREADY) while the test owns the memory.

Parameters:
AW, 12, byte address width; SRAM word address is AW-2 bits, N = 2^(AW-2) words

Ports:
HCLK  in  1  clock
HRESET  in  1  asynchronous reset, active high
F_SRAMCS  in  1  functional chip select from bridge
F_SRAMWEN  in  4  functional byte write enables (active high)
F_SRAMWDATA  in  32  functional write data
F_SRAMADDR  in  AW-2  functional word address
F_SRAMRDATA  out  32  read data to bridge
SRAMCS  out  1  chip select to SRAM
SRAMWEN  out  4  byte write enables to SRAM
SRAMWDATA  out  32  write data to SRAM
SRAMADDR  out  AW-2  word address to SRAM
SRAMRDATA  in  32  SRAM read data; valid the cycle after a read (CS=1, WEN=0)
bist_start  in  1  single-cycle start pulse
bist_active  out  1  BIST owns the SRAM (registered)
bist_done  out  1  sticky: last run completed
bist_fail  out  1  sticky: at least one mismatch in last run
bist_fail_addr  out  AW-2  word address of first mismatch
bist_fail_elem  out  3  march element (1..5) of first mismatch

Behaviour:
- Reset: state IDLE. bist_active, bist_done and bist_fail are 0. bist_fail_addr and bist_fail_elem are 0. Port is in pass-through.
- Pass-through (bist_active=0): SRAM* outputs equal the corresponding F_SRAM* inputs combinationally.
- F_SRAMRDATA = SRAMRDATA at all times (pure wire). A functional read issued the cycle before takeover still returns correct data.
- Mux select is the registered bist_active flag. There is no combinational path from bist_start to the SRAM* outputs.
- bist_start in IDLE: next edge sets bist_active=1 and clears bist_done, bist_fail, bist_fail_addr and bist_fail_elem. The march begins in that cycle.
- bist_start while bist_active=1: ignored.
- Data patterns: "0" = 32'h0000_0000, "1" = 32'hFFFF_FFFF. All writes use WEN=4'hF.
- Elements:
  - E0 up(w0): 1 cycle per address.
  - E1 up(r0,w1): 2 cycles per address.
  - E2 up(r1,w0): 2 cycles per address.
  - E3 down(r0,w1): 2 cycles per address.
  - E4 down(r1,w0): 2 cycles per address.
  - E5 any(r0): 1 cycle per address, ascending.
- Up order is 0..N-1; down order is N-1..0. The address counter wraps at element boundaries, with no idle cycle between elements.
- Read/write pairs: the read is issued in cycle t and the write to the same address in t+1. The compare happens in cycle t+1 against the registered expected value, element and address.
- E5 reads are back-to-back. The compare pipeline drains one extra cycle after the last E5 read, with SRAMCS=0 in that cycle.
- Total bist_active duration is exactly 10N+1 cycles. After that, bist_active=0 and bist_done=1 on the same edge, and the port returns to pass-through.
- Mismatch (SRAMRDATA != expected in a compare cycle): set bist_fail. If this is the first mismatch of the run, capture the address and element. Later mismatches do not overwrite the capture. The test always runs to completion.
- During BIST, SRAMCS=1 in every operation cycle. F_SRAM* inputs are ignored; the system must hold AHB off using bist_active.
- HRESET mid-run: immediate return to IDLE and pass-through, with all flags cleared. The SRAM contents are undefined after this.

Decomposition:
- Shared package mbist_pkg:
  - march element enum: E0..E5, DRAIN
  - operation type: RD, WR
  - pattern constants: PAT0, PAT1
  - per-element direction and expected/write pattern lookup function
- One natural sub-module, sram_march_seq. It holds the element FSM, the up/down address counter and the r/w phase. It outputs address, op, wdata, expected value and the element tag.
- The top level holds the output mux, the one-stage compare pipeline and the result flags.

Test Plan:
- AW=4 (N=4), fault-free SRAM model, pulse bist_start: bist_active high exactly 41 cycles, then bist_done=1, bist_fail=0, address sequence checked per element.
- Word 2 bit 3 stuck-at-1: bist_fail=1, bist_fail_addr=2, bist_fail_elem=1.
- Word 3 bit 0 stuck-at-0: bist_fail=1, bist_fail_addr=3, bist_fail_elem=2. Further mismatches in E4 do not change the capture.
- Idle pass-through: write 32'hDEADBEEF to addr 1 with WEN=4'hF, then read addr 1: SRAM* outputs mirror F_SRAM* in the same cycle, F_SRAMRDATA=32'hDEADBEEF the next cycle.
- bist_start pulsed again at cycle 10 of a run: ignored; run still ends at cycle 41. A later start clears bist_done and bist_fail.
- HRESET asserted at cycle 20 of a run: bist_active=0, all flags 0 immediately (asynchronous); pass-through works on the first cycle after release.
